// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the multi-cycle ALU (alu_mc, alu_iter).
//   op_e      : operation codes AND..MUL (codes 12-15 are unassigned/illegal)
//   state_e   : control FSM states IDLE / BUSY / DONE
//   DEF_*     : default datapath and op-code widths
//   is_iter_op: true for ops executed by the iterative datapath
// Optional feature macro: ALU_MC_MUL_EN (compiles the shift-add multiplier in).
package alu_pkg;

  localparam int DEF_REG_WIDTH = 8;
  localparam int DEF_OP_WIDTH  = 4;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_SLT  = 4'd1,
    OP_OR   = 4'd2,
    OP_NOT  = 4'd3,
    OP_ADD  = 4'd4,
    OP_SUB  = 4'd5,
    OP_PASS = 4'd6,
    OP_BEQ  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_SLL  = 4'd10,
    OP_MUL  = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ops that go through alu_iter. MUL only counts when the multiplier exists;
  // otherwise op 11 is decoded as an illegal single-cycle op.
  function automatic logic is_iter_op(input op_e code);
    case (code)
      OP_SRL, OP_SRA, OP_SLL: return 1'b1;
`ifdef ALU_MC_MUL_EN
      OP_MUL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_iter.sv
// alu_iter -- iterative datapath for shifts (one bit per cycle) and, when
// ALU_MC_MUL_EN is defined, an unsigned shift-add multiplier (W cycles).
// Ports:
//   clk, reset : clock, synchronous active-high reset (aborts any operation)
//   start      : load operands and begin; only pulsed while idle
//   op         : SRL / SRA / SLL / MUL
//   ra, rb     : operand, shift amount (or multiplier)
//   done       : high in the final cycle of an operation
//   hi, lo     : 2W-bit accumulator value after this cycle's step; valid with done
// The shift count is saturated at 2W; a count of 0 still takes one cycle and
// leaves the operand unchanged.
module alu_iter
  import alu_pkg::*;
#(
  parameter int W = DEF_REG_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  op_e          op,
  input  logic [W-1:0] ra,
  input  logic [W-1:0] rb,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(2 * W + 1);
  localparam logic [CW-1:0] MAX_SHIFT = CW'(2 * W);

  logic [2*W-1:0] acc_reg;
  logic [2*W-1:0] acc_step;
  logic [CW-1:0]  cnt_reg;     // cycles remaining; 0 means idle
  logic [CW-1:0]  shamt;
  logic           noshift_reg; // rb was 0: burn one cycle without shifting
  op_e            kind_reg;

`ifdef ALU_MC_MUL_EN
  logic [W-1:0] mcand_reg;
  logic [W:0]   mul_sum;
`endif

  // Saturate the shift amount at 2W (rb is compared one bit wider so 2W fits).
  assign shamt = ({1'b0, rb} >= (W + 1)'(2 * W)) ? MAX_SHIFT : CW'(rb);

  always_comb begin
    acc_step = acc_reg;
`ifdef ALU_MC_MUL_EN
    mul_sum = '0;
`endif
    if (!noshift_reg) begin
      case (kind_reg)
        OP_SRL: acc_step = acc_reg >> 1;
        OP_SRA: acc_step = {acc_reg[2*W-1], acc_reg[2*W-1:1]};
        OP_SLL: acc_step = acc_reg << 1;
`ifdef ALU_MC_MUL_EN
        // Upper half accumulates the partial product, lower half holds the
        // remaining multiplier bits; both shift right together each step.
        OP_MUL: begin
          mul_sum  = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
          acc_step = {mul_sum, acc_reg[W-1:1]};
        end
`endif
        default: acc_step = acc_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg     <= '0;
      cnt_reg     <= '0;
      noshift_reg <= 1'b0;
      kind_reg    <= OP_AND;
`ifdef ALU_MC_MUL_EN
      mcand_reg   <= '0;
`endif
    end else if (start) begin
      kind_reg <= op;
      case (op)
`ifdef ALU_MC_MUL_EN
        OP_MUL: begin
          acc_reg     <= {{W{1'b0}}, rb};
          mcand_reg   <= ra;
          cnt_reg     <= CW'(W);
          noshift_reg <= 1'b0;
        end
`endif
        OP_SLL: begin
          acc_reg     <= {{W{1'b0}}, ra};
          cnt_reg     <= (shamt == '0) ? CW'(1) : shamt;
          noshift_reg <= (shamt == '0);
        end
        default: begin
          acc_reg     <= {ra, {W{1'b0}}};
          cnt_reg     <= (shamt == '0) ? CW'(1) : shamt;
          noshift_reg <= (shamt == '0);
        end
      endcase
    end else if (cnt_reg != '0) begin
      acc_reg <= acc_step;
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign done = (cnt_reg == CW'(1));
  assign hi   = acc_step[2*W-1:W];
  assign lo   = acc_step[W-1:0];

endmodule

// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops (0-7, 12-15) complete the cycle after acceptance and can
// stream at one op per cycle; shifts (and MUL when ALU_MC_MUL_EN is defined)
// run in alu_iter while the FSM sits in BUSY.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake; ra_in, rb_in, op captured on accept
//   out_valid/out_ready : result handshake; outputs held while out_ready=0
//   res_out, car_out    : result and carry / high word
//   zero, branch, illegal : result flags, meaningful while out_valid=1
// Configuration macro: ALU_MC_MUL_EN (without it op 11 is illegal).
module alu_mc
  import alu_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int OP_WIDTH  = DEF_OP_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] ra_in,
  input  logic [REG_WIDTH-1:0] rb_in,
  input  logic [OP_WIDTH-1:0]  op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] res_out,
  output logic [REG_WIDTH-1:0] car_out,
  output logic                 zero,
  output logic                 branch,
  output logic                 illegal
);

  localparam int W = REG_WIDTH;

  state_e state_reg, state_next;

  logic [W-1:0] res_reg, car_reg;
  logic         branch_reg, illegal_reg;
  logic         res_hi_reg;  // iterative result: res from upper half (right shifts)

  logic accept, start_iter, load_single, load_iter;

  // Op decode. Codes that do not fit in 4 bits (wide OP_WIDTH) are illegal.
  logic [31:0] op_ext;
  op_e         op_dec;
  logic        op_oob;
  logic        multi_c;

  logic [W-1:0] res_c, car_c;
  logic         branch_c, illegal_c;
  logic [W:0]   add_sum;

  logic         iter_done;
  logic [W-1:0] iter_hi, iter_lo;

  assign op_ext  = 32'(op);
  assign op_dec  = op_e'(op_ext[3:0]);
  assign op_oob  = |op_ext[31:4];
  assign multi_c = !op_oob && is_iter_op(op_dec);

  // Single-cycle result computed straight from the input operands so it can
  // be registered on the accepting edge.
  always_comb begin
    res_c     = '0;
    car_c     = '0;
    branch_c  = 1'b0;
    illegal_c = 1'b0;
    add_sum   = '0;
    if (op_oob) begin
      illegal_c = 1'b1;
    end else begin
      case (op_dec)
        OP_AND:  res_c = ra_in & rb_in;
        OP_SLT:  res_c = {{(W-1){1'b0}}, ($signed(ra_in) < $signed(rb_in))};
        OP_OR:   res_c = ra_in | rb_in;
        OP_NOT:  res_c = ~ra_in;
        OP_ADD: begin
          add_sum = {1'b0, ra_in} + {1'b0, rb_in};
          res_c   = add_sum[W-1:0];
          car_c   = {{(W-1){1'b0}}, add_sum[W]};
        end
        OP_SUB: begin
          res_c = ra_in - rb_in;
          car_c = {{(W-1){1'b0}}, (ra_in < rb_in)};
        end
        OP_PASS: res_c = ra_in;
        OP_BEQ:  branch_c = (ra_in == rb_in);
        OP_SRL, OP_SRA, OP_SLL: res_c = '0;
`ifdef ALU_MC_MUL_EN
        OP_MUL:  res_c = '0;
`else
        OP_MUL:  illegal_c = 1'b1;
`endif
        default: illegal_c = 1'b1;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);

  always_comb begin
    state_next  = state_reg;
    start_iter  = 1'b0;
    load_single = 1'b0;
    load_iter   = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (multi_c) begin
            state_next = ST_BUSY;
            start_iter = 1'b1;
          end else begin
            state_next  = ST_DONE;
            load_single = 1'b1;
          end
        end else if ((state_reg == ST_DONE) && out_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (iter_done) begin
          state_next = ST_DONE;
          load_iter  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      res_reg     <= '0;
      car_reg     <= '0;
      branch_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      res_hi_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_single) begin
        res_reg     <= res_c;
        car_reg     <= car_c;
        branch_reg  <= branch_c;
        illegal_reg <= illegal_c;
      end else if (load_iter) begin
        res_reg     <= res_hi_reg ? iter_hi : iter_lo;
        car_reg     <= res_hi_reg ? iter_lo : iter_hi;
        branch_reg  <= 1'b0;
        illegal_reg <= 1'b0;
      end
      if (start_iter) begin
        res_hi_reg <= (op_dec == OP_SRL) || (op_dec == OP_SRA);
      end
    end
  end

  alu_iter #(
    .W(W)
  ) u_iter (
    .clk   (clk),
    .reset (reset),
    .start (start_iter),
    .op    (op_dec),
    .ra    (ra_in),
    .rb    (rb_in),
    .done  (iter_done),
    .hi    (iter_hi),
    .lo    (iter_lo)
  );

  assign res_out = res_reg;
  assign car_out = car_reg;
  assign zero    = (res_reg == '0);
  assign branch  = branch_reg;
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc -- scoreboard bench for alu_mc (W=8, OP_WIDTH=4).
// The driver pushes the reference-model result of every accepted op into a
// queue; an independent monitor compares each presented result (including its
// latency and its stability under backpressure) and pops it when consumed.
// Build with or without ALU_MC_MUL_EN; the model follows the same macro.
module tb_alu_mc;

  localparam int W  = 8;
  localparam int OW = 4;
`ifdef ALU_MC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] ra_in, rb_in;
  logic [OW-1:0] op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res_out, car_out;
  logic         zero, branch, illegal;

  always #5 clk = ~clk;

  alu_mc #(.REG_WIDTH(W), .OP_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ra_in(ra_in), .rb_in(rb_in), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .res_out(res_out), .car_out(car_out),
    .zero(zero), .branch(branch), .illegal(illegal)
  );

  typedef struct {
    int           op;
    logic [W-1:0] res;
    logic [W-1:0] car;
    logic         br;
    logic         ill;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   seen = 1'b0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural definition.
  function automatic exp_t model(input int o, input int a, input int b);
    exp_t   e;
    longint m1, m2, v, sv;
    int     n, sa, sbv;
    m1 = (longint'(1) << W) - 1;
    m2 = (longint'(1) << (2 * W)) - 1;
    n  = (b > 2 * W) ? 2 * W : b;
    e.op = o; e.res = '0; e.car = '0; e.br = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc_cyc = 0;
    v = 0;
    case (o)
      0: v = a & b;
      1: begin
        sa  = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sbv = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        v = (sa < sbv) ? 1 : 0;
      end
      2: v = a | b;
      3: v = (~a) & m1;
      4: begin v = a + b; e.car = W'(v >> W); end
      5: begin v = (a - b) & m1; e.car = (a < b) ? W'(1) : W'(0); end
      6: v = a;
      7: e.br = (a == b);
      8: begin
        v = (longint'(a) << W) >> n;
        e.car = W'(v & m1); v = v >> W;
        e.lat = ((n == 0) ? 1 : n) + 1;
      end
      9: begin
        sv = (a >= (1 << (W - 1))) ? longint'(a) - (longint'(1) << W) : longint'(a);
        sv = (sv * (longint'(1) << W)) >>> n;
        v = sv & m2;
        e.car = W'(v & m1); v = v >> W;
        e.lat = ((n == 0) ? 1 : n) + 1;
      end
      10: begin
        v = (longint'(a) << n) & m2;
        e.car = W'(v >> W);
        e.lat = ((n == 0) ? 1 : n) + 1;
      end
      11: begin
        if (MUL_ON) begin
          v = longint'(a) * longint'(b);
          e.car = W'(v >> W);
          e.lat = W + 1;
        end else begin
          e.ill = 1'b1;
        end
      end
      default: e.ill = 1'b1;
    endcase
    if (!e.ill && o != 7) e.res = W'(v & m1);
    return e;
  endfunction

  // Monitor: checks whatever the DUT presents against the head of the queue.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 0);
      end else begin
        mon_e = sb[0];
        if (!seen) chk("latency", cyc - mon_e.acc_cyc, mon_e.lat);
        seen = 1'b1;
        chk("res_out", res_out, mon_e.res);
        chk("car_out", car_out, mon_e.car);
        chk("zero", zero, (mon_e.res == '0));
        chk("branch", branch, mon_e.br);
        chk("illegal", illegal, mon_e.ill);
        if (out_ready) begin
          $display("txn op=%0d res=%02h car=%02h br=%0b ill=%0b lat=%0d",
                   mon_e.op, res_out, car_out, branch, illegal, mon_e.lat);
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Present one op and hold it until accepted; returns cycles spent waiting.
  task automatic issue(input int o, input int a, input int b, output int waits);
    exp_t e;
    in_valid = 1'b1; op = OW'(o); ra_in = W'(a); rb_in = W'(b);
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e = model(o, a, b);
        e.acc_cyc = cyc;
        sb.push_back(e);
        break;
      end
      waits++;
      if (waits > 200) begin
        chk("accept_timeout", in_ready, 1);
        break;
      end
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rand_ready) out_ready = ($urandom % 4) != 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int w, o, a, b;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ra_in = '0; rb_in = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res_out, 0);
    chk("rst_car", car_out, 0);
    chk("rst_zero", zero, 1);
    chk("rst_branch", branch, 0);
    chk("rst_illegal", illegal, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed corner cases.
    issue(4, 'hFF, 'h01, w);
    issue(5, 'h03, 'h05, w);
    issue(7, 'h5A, 'h5A, w);
    issue(9, 'h90, 3, w);
    issue(10, 'h81, 9, w);
    issue(8, 'hA7, 0, w);
    issue(11, 'hFF, 'hFF, w);
    drain();

    // Back-to-back single-cycle ops with the consumer always ready.
    for (int i = 0; i < 6; i++) begin
      o = $urandom_range(0, 7);
      issue(o, $urandom_range(0, 255), $urandom_range(0, 255), w);
      if (i > 0) chk("b2b_wait", w, 0);
    end
    drain();

    // Backpressure: result held, new request ignored for 5 cycles.
    issue(0, 'h3C, 'h0F, w);
    out_ready = 1'b0;
    in_valid = 1'b1; op = OW'(2); ra_in = 'h55; rb_in = 'hAA;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset during the 4th busy cycle of a long operation.
    issue(MUL_ON ? 11 : 10, 'hFF, 'hFF, w);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    seen = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_res", res_out, 0);
    chk("abort_car", car_out, 0);
    chk("abort_zero", zero, 1);
    chk("abort_in_ready", in_ready, 1);
    @(posedge clk); #1;
    issue(4, 'h10, 'h20, w);
    drain();

    // Randomized traffic with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      o = $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      b = ($urandom % 2) ? $urandom_range(0, 18) : $urandom_range(0, 255);
      issue(o, a, b, w);
    end
    rand_ready = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
